nodf_module_intf: RTL and testbench
===================================

# nodf_module_intf

Synthesizable monitor for the `ap_ctrl` block-level handshake of one non-dataflow HLS module, such as the top level or a called sub-function. It observes `ap_start`, `ap_ready`, `ap_done` and `ap_continue` and tracks per-transaction status. It accumulates counts and latency statistics, flags handshake protocol violations, and freezes all results when `finish` is asserted. It is purely passive and never drives the monitored module.

## Interface
- `CNT_W`, 32: width of event counters and the busy-cycle accumulator.
- `LAT_W`, 32: width of latency registers.

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `ap_start`  in  1  monitored module start request.
- `ap_ready`  in  1  monitored module ready for new inputs.
- `ap_done`  in  1  monitored module completion pulse.
- `ap_continue`  in  1  downstream acceptance of done; tie to 1 for `ap_ctrl_hs` modules.
- `finish`  in  1  end of observation; sticky effect.
- `state`  out  2  0=IDLE, 1=BUSY, 2=DONE_WAIT, 3=FINISHED.
- `start_count`  out  CNT_W  transactions started.
- `ready_count`  out  CNT_W  `ap_ready` cycles observed outside IDLE-without-start.
- `done_count`  out  CNT_W  transactions completed (done accepted).
- `last_latency`  out  LAT_W  latency of most recent completed transaction.
- `min_latency`  out  LAT_W  minimum latency; all-ones until first completion.
- `max_latency`  out  LAT_W  maximum latency.
- `busy_cycles`  out  CNT_W  total cycles spent executing.
- `txn_done`  out  1  one-cycle pulse per recorded latency.
- `proto_err`  out  2  sticky: [0] `ap_done` with no transaction in flight; [1] `ap_start` dropped in BUSY before `ap_ready` seen.
- `finished`  out  1  high in FINISHED.

## Operation
- **Latency:** done cycle minus start cycle, plus 1. A start and done in the same cycle gives latency 1.
- **Start event:** in IDLE with `ap_start`=1.
  - `start_count` increments and `busy_cycles` increments.
  - Internal `cur_lat` is set to 1.
  - Next state is BUSY unless the transaction also completes in the same cycle.
- **IDLE with `ap_start` and `ap_done` both high:** latency 1 is recorded.
  - If `ap_continue`=1: `done_count` increments and the block stays IDLE.
  - If `ap_continue`=0: next state is DONE_WAIT.
- **BUSY, every cycle:** `busy_cycles` increments.
  - If `ap_done`=0, `cur_lat` increments.
  - If `ap_done`=1, latency `cur_lat+1` is recorded into last/min/max and `txn_done` pulses. Next state is IDLE if `ap_continue`=1 (`done_count` increments), otherwise DONE_WAIT.
- **DONE_WAIT:** no latency or busy accumulation.
  - When `ap_continue`=1: `done_count` increments and the block returns to IDLE.
- **Back-to-back transactions:** `ap_start` still high in the cycle after a return to IDLE begins a new transaction.
- **`ap_ready` tracking:**
  - In BUSY, a per-transaction `ready_seen` flag is set by `ap_ready` and cleared at each start.
  - `ap_start`=0 in BUSY while `ready_seen`=0 and `ap_ready`=0 sets `proto_err[1]`.
  - `ap_done`=1 in IDLE with `ap_start`=0, or in DONE_WAIT, sets `proto_err[0]`. Such a done is not counted.
- **`finish`=1 in any state:** next state is FINISHED and the block stays there until reset.
  - All outputs freeze. An in-flight transaction is not counted as done.
  - The cycle in which `finish` is seen is still processed normally.
- **Saturation:** all counters and latencies saturate at all-ones with no wrap.

## Timing
- All outputs are registered. An event sampled at edge N is visible after edge N; `txn_done` is high for exactly that one following cycle.
- **Reset values** (asynchronous, immediate on assertion):
  - `state`=IDLE.
  - All counters, `last_latency`, `max_latency`, `proto_err`, `txn_done` and `finished` are 0.
  - `min_latency` is all-ones.
- **Reset mid-transaction:** the transaction is discarded and the block restarts in IDLE on the first edge after deassertion.
- **Zero-latency start+done:** single cycle; `start_count` and `done_count` both increment on the same edge.

## Test plan
- **Reset values:** assert reset mid-simulation with no clock edge.
  - Outputs go immediately to reset values (`min_latency`=0xFFFFFFFF, `state`=0).
- **Single transaction:** `ap_start` high from cycle 2 until `ap_ready`=`ap_done`=1 at cycle 6, `ap_continue`=1.
  - `start_count`=`done_count`=1, `last_latency`=`min_latency`=`max_latency`=5, `busy_cycles`=5.
  - `txn_done` high in cycle 7.
- **Back-to-back transactions:** latencies 3 then 7.
  - `min_latency`=3, `max_latency`=7, `last_latency`=7, `busy_cycles`=10, `done_count`=2.
- **Held `ap_continue`:** `ap_continue`=0 for 4 cycles after `ap_done`.
  - `state`=2 for 4 cycles, then `done_count`++ when `ap_continue` rises. Latency is unaffected and `busy_cycles` does not grow.
- **`finish` mid-transaction:** `finish` pulse in BUSY at latency 3.
  - `state`=3, `finished`=1, `start_count`=1, `done_count`=0.
  - A later `ap_start`/`ap_done` changes nothing.
- **Protocol errors:** `ap_done` in IDLE without start gives `proto_err`=01. `ap_start` dropped in BUSY before `ap_ready` gives `proto_err`=11. Reset clears both.

Source files
------------

// File: rtl/nodf_module_intf.sv
// Passive monitor for the ap_ctrl block-level handshake of one non-dataflow HLS module.
// Counts transactions, tracks latency statistics, flags protocol errors and freezes on finish.
module nodf_module_intf #(
  parameter int CNT_W = 32,
  parameter int LAT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] start_count,
  output logic [CNT_W-1:0] ready_count,
  output logic [CNT_W-1:0] done_count,
  output logic [LAT_W-1:0] last_latency,
  output logic [LAT_W-1:0] min_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic [CNT_W-1:0] busy_cycles,
  output logic             txn_done,
  output logic [1:0]       proto_err,
  output logic             finished
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] BUSY      = 2'd1;
  localparam logic [1:0] DONE_WAIT = 2'd2;
  localparam logic [1:0] FINISHED  = 2'd3;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + LAT_W'(1);
  endfunction

  logic [LAT_W-1:0] cur_lat;
  logic             ready_seen;

  logic             start_ev, busy_ev, done_rec, done_acc, ready_ev, err0, err1;
  logic [LAT_W-1:0] rec_lat;
  logic [1:0]       nstate;

  // Every event is qualified by a live state, so FINISHED suppresses all updates.
  always_comb begin
    start_ev = (state == IDLE) && ap_start;
    busy_ev  = start_ev || (state == BUSY);
    done_rec = busy_ev && ap_done;
    done_acc = (done_rec && ap_continue) || ((state == DONE_WAIT) && ap_continue);
    ready_ev = ap_ready && (start_ev || (state == BUSY) || (state == DONE_WAIT));
    err0     = ap_done && (((state == IDLE) && !ap_start) || (state == DONE_WAIT));
    err1     = (state == BUSY) && !ap_start && !ready_seen && !ap_ready;
    rec_lat  = (state == BUSY) ? lat_inc(cur_lat) : LAT_W'(1);

    nstate = state;
    case (state)
      IDLE:      if (start_ev) nstate = !ap_done ? BUSY : (ap_continue ? IDLE : DONE_WAIT);
      BUSY:      if (ap_done) nstate = ap_continue ? IDLE : DONE_WAIT;
      DONE_WAIT: if (ap_continue) nstate = IDLE;
      default:   nstate = FINISHED;
    endcase
    if (finish) nstate = FINISHED;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      start_count  <= '0;
      ready_count  <= '0;
      done_count   <= '0;
      last_latency <= '0;
      min_latency  <= '1;
      max_latency  <= '0;
      busy_cycles  <= '0;
      txn_done     <= 1'b0;
      proto_err    <= 2'b00;
      finished     <= 1'b0;
      cur_lat      <= '0;
      ready_seen   <= 1'b0;
    end else begin
      state    <= nstate;
      finished <= (nstate == FINISHED);
      txn_done <= done_rec;

      if (start_ev) start_count <= cnt_inc(start_count);
      if (ready_ev) ready_count <= cnt_inc(ready_count);
      if (done_acc) done_count  <= cnt_inc(done_count);
      if (busy_ev)  busy_cycles <= cnt_inc(busy_cycles);

      if (start_ev)
        cur_lat <= LAT_W'(1);
      else if ((state == BUSY) && !ap_done)
        cur_lat <= lat_inc(cur_lat);

      if (start_ev)
        ready_seen <= 1'b0;
      else if ((state == BUSY) && ap_ready)
        ready_seen <= 1'b1;

      if (done_rec) begin
        last_latency <= rec_lat;
        if (rec_lat < min_latency) min_latency <= rec_lat;
        if (rec_lat > max_latency) max_latency <= rec_lat;
      end

      if (err0) proto_err[0] <= 1'b1;
      if (err1) proto_err[1] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed bench for nodf_module_intf: a cycle-stamped transaction model checked every cycle,
// plus literal expectations after each scenario.
module tb_nodf_module_intf;
  logic clock = 1'b0, reset = 1'b1;
  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1, finish = 1'b0;
  logic [1:0]  state, proto_err;
  logic [31:0] start_count, ready_count, done_count, last_latency, min_latency, max_latency, busy_cycles;
  logic        txn_done, finished;

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  nodf_module_intf #(.CNT_W(32), .LAT_W(32)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .ap_continue(ap_continue), .finish(finish), .state(state), .start_count(start_count),
    .ready_count(ready_count), .done_count(done_count), .last_latency(last_latency),
    .min_latency(min_latency), .max_latency(max_latency), .busy_cycles(busy_cycles),
    .txn_done(txn_done), .proto_err(proto_err), .finished(finished)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Model: a transaction is the interval from its start cycle to its done cycle.
  int       cyc, t0, s, lat;
  bit       launch, running, m_rdy, m_txn;
  int       m_state;
  longint   m_start, m_ready, m_done, m_last, m_min, m_max, m_busy;
  bit [1:0] m_err;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_state = 0; m_start = 0; m_ready = 0; m_done = 0; m_last = 0; m_max = 0;
      m_min = 64'hFFFF_FFFF; m_busy = 0; m_txn = 0; m_rdy = 0; m_err = 0;
    end else begin
      cyc++;
      m_txn = 0;
      if (m_state != 3) begin
        s       = m_state;
        launch  = (s == 0) && ap_start;
        running = launch || (s == 1);
        if (ap_ready && (s != 0 || ap_start)) m_ready++;
        if (launch) begin t0 = cyc; m_start++; m_rdy = 0; end
        if (running) m_busy++;
        if (s == 1) begin
          if (ap_ready) m_rdy = 1;
          else if (!ap_start && !m_rdy) m_err[1] = 1;
        end
        if (running && ap_done) begin
          lat = cyc - t0 + 1;
          m_last = lat;
          if (lat < m_min) m_min = lat;
          if (lat > m_max) m_max = lat;
          m_txn = 1;
          if (ap_continue) begin m_done++; m_state = 0; end
          else m_state = 2;
        end else if (launch) m_state = 1;
        else if (ap_done) m_err[0] = 1;
        if (s == 2 && ap_continue) begin m_done++; m_state = 0; end
        if (finish) m_state = 3;
      end
    end
  end

  always @(negedge clock) if (chk_en) begin
    check("state", state, m_state);
    check("start_count", start_count, m_start);
    check("ready_count", ready_count, m_ready);
    check("done_count", done_count, m_done);
    check("last_latency", last_latency, m_last);
    check("min_latency", min_latency, m_min);
    check("max_latency", max_latency, m_max);
    check("busy_cycles", busy_cycles, m_busy);
    check("txn_done", txn_done, m_txn);
    check("proto_err", proto_err, m_err);
    check("finished", finished, m_state == 3);
  end

  // Apply one vector for one cycle; returns at the negedge where its effect is visible.
  task automatic drive(input bit st, input bit rd, input bit dn, input bit ct, input bit fn);
    ap_start = st; ap_ready = rd; ap_done = dn; ap_continue = ct; finish = fn;
    @(negedge clock);
  endtask

  task automatic do_reset();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    #2 reset = 1'b1;
    #1;
    check("rst_state", state, 0);
    check("rst_min", min_latency, 32'hFFFF_FFFF);
    check("rst_max", max_latency, 0);
    check("rst_last", last_latency, 0);
    check("rst_start", start_count, 0);
    check("rst_done", done_count, 0);
    check("rst_ready", ready_count, 0);
    check("rst_busy", busy_cycles, 0);
    check("rst_err", proto_err, 0);
    check("rst_txn", txn_done, 0);
    check("rst_fin", finished, 0);
    #1 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single transaction, latency 5
    drive(0, 0, 0, 1, 0);
    repeat (4) drive(1, 0, 0, 1, 0);
    drive(1, 1, 1, 1, 0);
    check("single_txn_done", txn_done, 1);
    check("single_start", start_count, 1);
    check("single_done", done_count, 1);
    check("single_last", last_latency, 5);
    check("single_min", min_latency, 5);
    check("single_max", max_latency, 5);
    check("single_busy", busy_cycles, 5);
    check("single_ready", ready_count, 1);
    drive(0, 0, 0, 1, 0);
    check("single_txn_drop", txn_done, 0);

    // Asynchronous reset with nonzero statistics
    do_reset();

    // Back-to-back, latencies 3 then 7
    repeat (2) drive(1, 0, 0, 1, 0);
    drive(1, 1, 1, 1, 0);
    repeat (6) drive(1, 0, 0, 1, 0);
    drive(1, 1, 1, 1, 0);
    check("b2b_min", min_latency, 3);
    check("b2b_max", max_latency, 7);
    check("b2b_last", last_latency, 7);
    check("b2b_busy", busy_cycles, 10);
    check("b2b_done", done_count, 2);
    check("b2b_start", start_count, 2);
    drive(0, 0, 0, 1, 0);

    // Held ap_continue
    do_reset();
    repeat (2) drive(1, 0, 0, 1, 0);
    drive(1, 1, 1, 0, 0);
    check("hold_state0", state, 2);
    check("hold_done0", done_count, 0);
    for (int i = 1; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      check("hold_state", state, 2);
      check("hold_busy", busy_cycles, 3);
    end
    drive(0, 0, 0, 1, 0);
    check("hold_release", state, 0);
    check("hold_done", done_count, 1);
    check("hold_last", last_latency, 3);

    // Zero-latency start+done
    drive(1, 1, 1, 1, 0);
    check("zl_start", start_count, 2);
    check("zl_done", done_count, 2);
    check("zl_last", last_latency, 1);
    check("zl_min", min_latency, 1);
    check("zl_state", state, 0);
    drive(0, 0, 0, 1, 0);

    // finish mid-transaction
    do_reset();
    repeat (2) drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 1, 1);
    check("fin_state", state, 3);
    check("fin_flag", finished, 1);
    check("fin_start", start_count, 1);
    check("fin_done", done_count, 0);
    check("fin_busy", busy_cycles, 3);
    drive(1, 1, 1, 1, 0);
    drive(0, 0, 1, 1, 0);
    check("fin_frozen_start", start_count, 1);
    check("fin_frozen_done", done_count, 0);
    check("fin_frozen_err", proto_err, 0);
    check("fin_frozen_state", state, 3);

    // Protocol errors
    do_reset();
    drive(0, 0, 1, 1, 0);
    check("err_done_idle", proto_err, 2'b01);
    check("err_done_uncounted", done_count, 0);
    drive(1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    check("err_start_drop", proto_err, 2'b11);
    do_reset();

    repeat (2) drive(0, 0, 0, 1, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
